// File: rtl/wb_arbiter.sv
// Writeback arbiter: picks one completed result per cycle from the ALU or LSU
// channel, drives the single register-file write port, and tracks a busy
// scoreboard of destinations that have been issued but not yet written back.
module wb_arbiter #(
    parameter int XLEN       = 32,
    parameter int NREGS      = 32,
    parameter int AW         = $clog2(NREGS),
    parameter int STARVE_MAX = 3
) (
    input  logic             clk_i,
    input  logic             arst_ni,

    input  logic             iss_valid_i,
    input  logic [AW-1:0]    iss_rd_i,
    output logic [NREGS-1:0] busy_o,

    input  logic             alu_valid_i,
    output logic             alu_ready_o,
    input  logic [AW-1:0]    alu_rd_i,
    input  logic [XLEN-1:0]  alu_data_i,

    input  logic             lsu_valid_i,
    output logic             lsu_ready_o,
    input  logic [AW-1:0]    lsu_rd_i,
    input  logic [XLEN-1:0]  lsu_data_i,

    output logic             wen_o,
    output logic [AW-1:0]    waddr_o,
    output logic [XLEN-1:0]  wdata_o
);

    localparam int            SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_ALU,
        GRANT_LSU
    } grant_t;

    grant_t            grant;
    logic [SW-1:0]     starve_cnt;
    logic [SW-1:0]     starve_next;
    logic              xfer_valid;
    logic [AW-1:0]     xfer_rd;
    logic [XLEN-1:0]   xfer_data;
    logic [NREGS-1:0]  set_mask;
    logic [NREGS-1:0]  clr_mask;
    logic [NREGS-1:0]  busy_next;

    // Arbitration: LSU normally wins, ALU wins once it has been starved long enough.
    // Readys are forced low while reset is held so nothing is accepted mid-reset.
    always_comb begin
        grant = GRANT_NONE;
        if (arst_ni) begin
            if (alu_valid_i && (!lsu_valid_i || starve_cnt == STARVE_LIM)) begin
                grant = GRANT_ALU;
            end else if (lsu_valid_i) begin
                grant = GRANT_LSU;
            end
        end
        alu_ready_o = (grant == GRANT_ALU);
        lsu_ready_o = (grant == GRANT_LSU);
    end

    // Select the payload of whichever channel completes a transfer this cycle.
    always_comb begin
        xfer_valid = 1'b0;
        xfer_rd    = '0;
        xfer_data  = '0;
        case (grant)
            GRANT_ALU: begin
                xfer_valid = 1'b1;
                xfer_rd    = alu_rd_i;
                xfer_data  = alu_data_i;
            end
            GRANT_LSU: begin
                xfer_valid = 1'b1;
                xfer_rd    = lsu_rd_i;
                xfer_data  = lsu_data_i;
            end
            default: begin
                xfer_valid = 1'b0;
            end
        endcase
    end

    // Starvation counter: counts cycles the ALU waits, saturating, cleared when it wins.
    always_comb begin
        starve_next = starve_cnt;
        if (grant == GRANT_ALU) begin
            starve_next = '0;
        end else if (alu_valid_i && starve_cnt != STARVE_LIM) begin
            starve_next = starve_cnt + SW'(1);
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_next;
        end
    end

    // Registered write port; writes to x0 are swallowed and leave addr/data untouched.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            wen_o   <= 1'b0;
            waddr_o <= '0;
            wdata_o <= '0;
        end else if (xfer_valid && xfer_rd != '0) begin
            wen_o   <= 1'b1;
            waddr_o <= xfer_rd;
            wdata_o <= xfer_data;
        end else begin
            wen_o   <= 1'b0;
        end
    end

    // Scoreboard update masks; a set on the same register as a clear takes priority
    // because a newer producer is now outstanding. Register 0 is never marked busy.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (iss_valid_i && iss_rd_i != '0) begin
            set_mask[iss_rd_i] = 1'b1;
        end
        if (xfer_valid) begin
            clr_mask[xfer_rd] = 1'b1;
        end
        busy_next    = (busy_o & ~clr_mask) | set_mask;
        busy_next[0] = 1'b0;
    end

    // Scoreboard register seen by decode.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            busy_o <= '0;
        end else begin
            busy_o <= busy_next;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed scenarios with literal expectations plus
// randomized producer traffic checked every cycle against a behavioural model.
module tb_wb_arbiter;

    localparam int XLEN       = 32;
    localparam int NREGS      = 32;
    localparam int AW         = 5;
    localparam int STARVE_MAX = 3;

    logic             clk;
    logic             arst_ni;
    logic             iss_valid;
    logic [AW-1:0]    iss_rd;
    logic [NREGS-1:0] busy;
    logic             alu_valid;
    logic             alu_ready;
    logic [AW-1:0]    alu_rd;
    logic [XLEN-1:0]  alu_data;
    logic             lsu_valid;
    logic             lsu_ready;
    logic [AW-1:0]    lsu_rd;
    logic [XLEN-1:0]  lsu_data;
    logic             wen;
    logic [AW-1:0]    waddr;
    logic [XLEN-1:0]  wdata;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    // Behavioural model state
    logic [NREGS-1:0] m_busy   = '0;
    logic             m_wen    = 1'b0;
    logic [AW-1:0]    m_waddr  = '0;
    logic [XLEN-1:0]  m_wdata  = '0;
    int               m_starve = 0;

    wb_arbiter #(
        .XLEN(XLEN), .NREGS(NREGS), .AW(AW), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk_i(clk),
        .arst_ni(arst_ni),
        .iss_valid_i(iss_valid),
        .iss_rd_i(iss_rd),
        .busy_o(busy),
        .alu_valid_i(alu_valid),
        .alu_ready_o(alu_ready),
        .alu_rd_i(alu_rd),
        .alu_data_i(alu_data),
        .lsu_valid_i(lsu_valid),
        .lsu_ready_o(lsu_ready),
        .lsu_rd_i(lsu_rd),
        .lsu_data_i(lsu_data),
        .wen_o(wen),
        .waddr_o(waddr),
        .wdata_o(wdata)
    );

    // Free-running clock, 10 time-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Who should win this cycle: 0 none, 1 ALU, 2 LSU
    function automatic int exp_grant();
        if (!arst_ni) return 0;
        if (alu_valid && lsu_valid) return (m_starve == STARVE_MAX) ? 1 : 2;
        if (alu_valid) return 1;
        if (lsu_valid) return 2;
        return 0;
    endfunction

    function automatic logic [AW-1:0] exp_rd();
        return (exp_grant() == 1) ? alu_rd : lsu_rd;
    endfunction

    function automatic logic [XLEN-1:0] exp_data();
        return (exp_grant() == 1) ? alu_data : lsu_data;
    endfunction

    function automatic logic [NREGS-1:0] exp_busy_next();
        logic [NREGS-1:0] b;
        b = m_busy;
        if (exp_grant() != 0) b[exp_rd()] = 1'b0;
        if (iss_valid && iss_rd != 0) b[iss_rd] = 1'b1;
        return b;
    endfunction

    // Model advances at each clock edge, and clears on async reset
    always @(posedge clk or negedge arst_ni) begin
        if (!arst_ni) begin
            m_busy   <= '0;
            m_wen    <= 1'b0;
            m_waddr  <= '0;
            m_wdata  <= '0;
            m_starve <= 0;
        end else begin
            m_busy <= exp_busy_next();
            if (exp_grant() != 0 && exp_rd() != 0) begin
                m_wen   <= 1'b1;
                m_waddr <= exp_rd();
                m_wdata <= exp_data();
            end else begin
                m_wen <= 1'b0;
            end
            if (exp_grant() == 1) m_starve <= 0;
            else if (alu_valid && m_starve < STARVE_MAX) m_starve <= m_starve + 1;
        end
    end

    // Compare every output against the model mid-cycle
    always @(negedge clk) begin
        if (cmp_en) begin
            checkOutput("model_alu_ready", alu_ready, exp_grant() == 1);
            checkOutput("model_lsu_ready", lsu_ready, exp_grant() == 2);
            checkOutput("model_wen", wen, m_wen);
            checkOutput("model_waddr", waddr, m_waddr);
            checkOutput("model_wdata", wdata, m_wdata);
            checkOutput("model_busy", busy, m_busy);
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs and stop mid-cycle so readys can be inspected
    task automatic applyStimulus(input logic iv, input logic [AW-1:0] ird,
                                 input logic av, input logic [AW-1:0] ard, input logic [XLEN-1:0] ad,
                                 input logic lv, input logic [AW-1:0] lrd, input logic [XLEN-1:0] ld);
        iss_valid = iv;  iss_rd   = ird;
        alu_valid = av;  alu_rd   = ard;  alu_data = ad;
        lsu_valid = lv;  lsu_rd   = lrd;  lsu_data = ld;
        @(negedge clk);
    endtask

    initial begin
        bit a_x;
        bit l_x;
        bit exp_alu;
        int ak;
        int lj;

        arst_ni = 1'b0;
        iss_valid = 1'b0; iss_rd = '0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        cmp_en = 1'b1;
        repeat (3) @(negedge clk);
        #2 arst_ni = 1'b1;
        nextCycle();

        // Reset values
        checkOutput("reset_busy", busy, 32'h0);
        checkOutput("reset_wen", wen, 1'b0);
        checkOutput("reset_waddr", waddr, 5'd0);
        checkOutput("reset_wdata", wdata, 32'h0);

        // Latency: issue x7, then ALU writes it back one cycle after acceptance
        applyStimulus(1, 5'd7, 0, 0, 0, 0, 0, 0);
        nextCycle();
        applyStimulus(0, 0, 1, 5'd7, 32'hDEADBEEF, 0, 0, 0);
        checkOutput("lat_alu_ready", alu_ready, 1'b1);
        checkOutput("lat_busy7_set", busy[7], 1'b1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("lat_wen", wen, 1'b1);
        checkOutput("lat_waddr", waddr, 5'd7);
        checkOutput("lat_wdata", wdata, 32'hDEADBEEF);
        checkOutput("lat_busy7_clr", busy[7], 1'b0);
        nextCycle();

        // Starvation: both channels always valid -> L,L,L,A,L,L,L,A
        ak = 0;
        lj = 0;
        for (int c = 0; c < 8; c++) begin
            applyStimulus(0, 0, 1, 5'(20 + ak), 32'hA0000000 + 32'(ak),
                          1, 5'(11 + lj), 32'hB0000000 + 32'(lj));
            exp_alu = (c == 3 || c == 7);
            checkOutput("starve_alu_ready", alu_ready, exp_alu);
            checkOutput("starve_lsu_ready", lsu_ready, !exp_alu);
            if (exp_alu) ak++;
            else lj++;
            nextCycle();
        end

        // x0: accepted but never written, scoreboard untouched
        applyStimulus(1, 5'd0, 0, 0, 0, 1, 5'd0, 32'hFFFFFFFF);
        checkOutput("x0_lsu_ready", lsu_ready, 1'b1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("x0_wen", wen, 1'b0);
        checkOutput("x0_waddr_hold", waddr, 5'd21);
        checkOutput("x0_wdata_hold", wdata, 32'hA0000001);
        checkOutput("x0_busy", busy, 32'h0);
        nextCycle();

        // Set wins over clear on the same register
        applyStimulus(1, 5'd3, 0, 0, 0, 0, 0, 0);
        nextCycle();
        applyStimulus(1, 5'd3, 1, 5'd3, 32'h33, 0, 0, 0);
        checkOutput("setwin_alu_ready", alu_ready, 1'b1);
        checkOutput("setwin_busy3_before", busy[3], 1'b1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("setwin_wen", wen, 1'b1);
        checkOutput("setwin_waddr", waddr, 5'd3);
        checkOutput("setwin_wdata", wdata, 32'h33);
        checkOutput("setwin_busy3_after", busy[3], 1'b1);
        nextCycle();

        // Back-to-back LSU writes with no bubbles
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 1, 5'(i), 32'h100 + 32'(i));
            checkOutput("b2b_lsu_ready", lsu_ready, 1'b1);
            if (i > 1) begin
                checkOutput("b2b_wen", wen, 1'b1);
                checkOutput("b2b_waddr", waddr, 5'(i - 1));
            end
            nextCycle();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("b2b_last_wen", wen, 1'b1);
        checkOutput("b2b_last_waddr", waddr, 5'd4);
        checkOutput("b2b_last_wdata", wdata, 32'h104);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("b2b_idle_wen", wen, 1'b0);
        nextCycle();

        // Reset in the middle of a write
        applyStimulus(1, 5'd9, 1, 5'd5, 32'h1234, 0, 0, 0);
        checkOutput("rst_alu_ready", alu_ready, 1'b1);
        nextCycle();
        checkOutput("rst_pre_wen", wen, 1'b1);
        checkOutput("rst_pre_waddr", waddr, 5'd5);
        alu_rd = 5'd6;
        #1 arst_ni = 1'b0;
        #1;
        checkOutput("rst_async_wen", wen, 1'b0);
        checkOutput("rst_async_busy", busy, 32'h0);
        checkOutput("rst_async_waddr", waddr, 5'd0);
        checkOutput("rst_async_wdata", wdata, 32'h0);
        checkOutput("rst_alu_ready_low", alu_ready, 1'b0);
        @(negedge clk);
        iss_valid = 1'b0;
        alu_valid = 1'b0;
        #2 arst_ni = 1'b1;
        nextCycle();

        // Randomized traffic; producers hold their item until it is accepted
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            a_x = alu_valid && alu_ready;
            l_x = lsu_valid && lsu_ready;
            nextCycle();
            if (!alu_valid || a_x) begin
                alu_valid = ($urandom_range(0, 2) != 0);
                alu_rd    = 5'($urandom_range(0, 31));
                alu_data  = $urandom;
            end
            if (!lsu_valid || l_x) begin
                lsu_valid = ($urandom_range(0, 2) != 0);
                lsu_rd    = 5'($urandom_range(0, 31));
                lsu_data  = $urandom;
            end
            iss_valid = ($urandom_range(0, 1) != 0);
            iss_rd    = 5'($urandom_range(0, 31));
        end

        iss_valid = 1'b0;
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
